// File: rtl/hdub_core_logic_gate_checker_if.sv
// Gate-checker bundle: run handshake, operand/result pair towards the gate
// under test, and run status. The checker is the master end.
interface hdub_core_logic_gate_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic             lhs;
  logic             rhs;
  logic             result;
  logic [1:0]       vec_idx;
  logic [ERR_W-1:0] err_count;
  logic [1:0]       first_fail;

  modport master (
    input  start, result,
    output busy, done, pass, lhs, rhs, vec_idx, err_count, first_fail
  );

  modport slave (
    output start, result,
    input  busy, done, pass, lhs, rhs, vec_idx, err_count, first_fail
  );
endinterface

// File: rtl/hdub_core_logic_gate_checker.sv
// Truth-table stimulus/response checker for a single gate type: sweeps every
// input vector PASSES times, samples the gate after a settle delay, counts errors.
package hdub_core_logic_gate;
  localparam int GATE_AND = 0;
  localparam int GATE_OR  = 1;
  localparam int GATE_XOR = 2;
  localparam int GATE_NOT = 3;
endpackage

module hdub_core_logic_gate_checker #(
  parameter int GATE_TYPE     = hdub_core_logic_gate::GATE_AND,
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input logic                           clk,
  input logic                           reset,
  hdub_core_logic_gate_checker_if.master gif
);

  localparam int NVEC = (GATE_TYPE == hdub_core_logic_gate::GATE_NOT) ? 2 : 4;
  localparam int SW   = $clog2(SETTLE_CYCLES + 1);
  localparam int PW   = (PASSES < 2) ? 1 : $clog2(PASSES);

  localparam logic [SW-1:0]    SETTLE_LD  = SW'(SETTLE_CYCLES);
  localparam logic [SW-1:0]    SETTLE_ONE = SW'(1);
  localparam logic [PW-1:0]    PASS_LAST  = PW'(PASSES - 1);
  localparam logic [PW-1:0]    PASS_ONE   = PW'(1);
  localparam logic [1:0]       VEC_LAST   = 2'(NVEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO   = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (GATE_TYPE != hdub_core_logic_gate::GATE_AND && GATE_TYPE != hdub_core_logic_gate::GATE_OR &&
      GATE_TYPE != hdub_core_logic_gate::GATE_XOR && GATE_TYPE != hdub_core_logic_gate::GATE_NOT) begin : g_bad_gate
    $error("hdub_core_logic_gate_checker: unsupported GATE_TYPE");
  end
  if (SETTLE_CYCLES < 1 || PASSES < 1) begin : g_bad_count
    $error("hdub_core_logic_gate_checker: SETTLE_CYCLES and PASSES must be >= 1");
  end

  // {lhs, rhs} for a vector index; the inverter only uses the low index bit.
  function automatic logic [1:0] operands_f(input logic [1:0] v);
    if (NVEC == 2) begin
      operands_f = {v[0], 1'b0};
    end else begin
      operands_f = v;
    end
  endfunction

  function automatic logic expected_f(input logic a, input logic b);
    case (GATE_TYPE)
      hdub_core_logic_gate::GATE_AND: expected_f = a & b;
      hdub_core_logic_gate::GATE_OR:  expected_f = a | b;
      hdub_core_logic_gate::GATE_XOR: expected_f = a ^ b;
      hdub_core_logic_gate::GATE_NOT: expected_f = ~a;
      default:                        expected_f = 1'b0;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [1:0]       vec_q, vec_d;
  logic [1:0]       ops_q, ops_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [1:0]       ff_q, ff_d;
  logic             mismatch_s;
  logic             last_s;

  assign mismatch_s = (gif.result != expected_f(ops_q[1], ops_q[0]));
  assign last_s     = (vec_q == VEC_LAST) && (pcnt_q == PASS_LAST);

  // Next-state: launch from IDLE, step vectors on each settle expiry, one-cycle DONE.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pcnt_d   = pcnt_q;
    vec_d    = vec_q;
    ops_d    = ops_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    case (state_q)
      S_IDLE: begin
        if (gif.start) begin
          state_d  = S_RUN;
          busy_d   = 1'b1;
          vec_d    = 2'd0;
          ops_d    = operands_f(2'd0);
          err_d    = ERR_ZERO;
          ff_d     = 2'd0;
          pass_d   = 1'b0;
          settle_d = SETTLE_LD;
          pcnt_d   = {PW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (settle_q == SETTLE_ONE) begin
          if (mismatch_s) begin
            err_d = (err_q == ERR_MAX) ? err_q : err_q + ERR_ONE;
            ff_d  = (err_q == ERR_ZERO) ? vec_q : ff_q;
          end else begin
            err_d = err_q;
            ff_d  = ff_q;
          end
          if (last_s) begin
            // Final sample of the last sweep: report and park operands at 0.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == ERR_ZERO);
            vec_d   = 2'd0;
            ops_d   = 2'd0;
            settle_d = {SW{1'b0}};
          end else begin
            settle_d = SETTLE_LD;
            if (vec_q == VEC_LAST) begin
              vec_d  = 2'd0;
              pcnt_d = pcnt_q + PASS_ONE;
            end else begin
              vec_d  = vec_q + 2'd1;
              pcnt_d = pcnt_q;
            end
            ops_d = operands_f(vec_d);
          end
        end else begin
          settle_d = settle_q - SETTLE_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      settle_q <= {SW{1'b0}};
      pcnt_q   <= {PW{1'b0}};
      vec_q    <= 2'd0;
      ops_q    <= 2'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= ERR_ZERO;
      ff_q     <= 2'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pcnt_q   <= pcnt_d;
      vec_q    <= vec_d;
      ops_q    <= ops_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
    end
  end

  assign gif.busy       = busy_q;
  assign gif.done       = done_q;
  assign gif.pass       = pass_q;
  assign gif.lhs        = ops_q[1];
  assign gif.rhs        = ops_q[0];
  assign gif.vec_idx    = vec_q;
  assign gif.err_count  = err_q;
  assign gif.first_fail = ff_q;

endmodule
